// File: rtl/reg_file_wb_pkg.sv
// Shared definitions for the register file, its write-back stage and the
// neighbouring ALU / control blocks.
package reg_file_wb_pkg;

    // Operand/result width and register address width.
    localparam int DATA_W = 8;
    localparam int ADDR_W = 3;
    localparam int NREGS  = 1 << ADDR_W;

    // Nominal timing of the read path and of the edge-to-array update, in
    // time units. These describe the timing for behavioural models and
    // timing budgets only; the synthesizable logic is zero-delay.
    localparam int READ_DLY  = 2;
    localparam int WRITE_DLY = 1;

    // One captured write-back: a bubble has valid=0.
    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              zero;
    } wb_entry_t;

    // True when a read of addr must be served from the pending write-back.
    function automatic logic bypass_hit(input wb_entry_t entry,
                                        input logic [ADDR_W-1:0] addr);
        return entry.valid && (entry.addr == addr);
    endfunction

endpackage

// File: rtl/reg_file_wb_pipe_reg.sv
// Write-back capture register: holds the ALU result for one cycle between
// the ALU and the register array. Freezes on stall, clears on reset.
module wb_pipe_reg
    import reg_file_wb_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      stall,
    input  wb_entry_t capture,
    output wb_entry_t entry
);

    // Capture a new write (or bubble) every unstalled edge; reset drops it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry <= '0;
        end else if (!stall) begin
            entry <= capture;
        end
    end

endmodule

// File: rtl/reg_file_wb.sv
// 8x8 register file with a one-stage write-back register and read bypass.
// The ALU result is captured first and written into the array one edge
// later; reads that hit the pending write see it through the bypass, so a
// dependent instruction issued right behind its producer reads fresh data.
module reg_file_wb
    import reg_file_wb_pkg::*;
(
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic [DATA_W-1:0] IN,
    input  logic              ZERO_IN,
    input  logic [ADDR_W-1:0] INADDRESS,
    input  logic              WRITEENABLE,
    input  logic              STALL,
    input  logic [ADDR_W-1:0] OUT1ADDRESS,
    input  logic [ADDR_W-1:0] OUT2ADDRESS,
    output logic [DATA_W-1:0] OUT1,
    output logic [DATA_W-1:0] OUT2,
    output logic              ZERO_FLAG,
    output logic              WB_PENDING
);

    wb_entry_t         capture_p0;
    wb_entry_t         wb_p1;
    logic              commit;
    logic [DATA_W-1:0] regs [NREGS];

    // Stage p0: pack the incoming ALU result into a write-back entry.
    always_comb begin
        capture_p0.valid = WRITEENABLE;
        capture_p0.addr  = INADDRESS;
        capture_p0.data  = IN;
        capture_p0.zero  = ZERO_IN;
    end

    wb_pipe_reg u_wb_pipe_reg (
        .clk     (CLK),
        .rst_n   (RESET_N),
        .stall   (STALL),
        .capture (capture_p0),
        .entry   (wb_p1)
    );

    // Stage p1: the older entry retires on the same edge the newer one is
    // captured, so the array always sees writes in program order.
    always_comb begin
        commit = wb_p1.valid && !STALL;
    end

    // Array update from the pending entry; reset clears every register.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (commit) begin
            regs[wb_p1.addr] <= wb_p1.data;
        end
    end

    // ZERO of the last committed write; bubbles leave it untouched.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            ZERO_FLAG <= 1'b0;
        end else if (commit) begin
            ZERO_FLAG <= wb_p1.zero;
        end
    end

    // Two independent read ports, each bypassing the pending write on a hit.
    always_comb begin
        OUT1 = bypass_hit(wb_p1, OUT1ADDRESS) ? wb_p1.data : regs[OUT1ADDRESS];
        OUT2 = bypass_hit(wb_p1, OUT2ADDRESS) ? wb_p1.data : regs[OUT2ADDRESS];
    end

    // Pending indicator follows the captured valid bit directly.
    always_comb begin
        WB_PENDING = wb_p1.valid;
    end

endmodule

// File: tb/tb_reg_file_wb.sv
// Self-checking bench for reg_file_wb: directed stimulus pushes the
// hand-computed expected outputs for each cycle into a queue, and a monitor
// on the falling edge pops and compares them.
module tb_reg_file_wb;

    logic       clk;
    logic       rst_n;
    logic [7:0] din;
    logic       zin;
    logic [2:0] waddr;
    logic       we;
    logic       stall;
    logic [2:0] a1;
    logic [2:0] a2;
    logic [7:0] out1;
    logic [7:0] out2;
    logic       zflag;
    logic       pend;

    typedef struct {
        string      name;
        logic [7:0] o1;
        logic [7:0] o2;
        logic       zf;
        logic       pend;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    reg_file_wb dut (
        .CLK         (clk),
        .RESET_N     (rst_n),
        .IN          (din),
        .ZERO_IN     (zin),
        .INADDRESS   (waddr),
        .WRITEENABLE (we),
        .STALL       (stall),
        .OUT1ADDRESS (a1),
        .OUT2ADDRESS (a2),
        .OUT1        (out1),
        .OUT2        (out2),
        .ZERO_FLAG   (zflag),
        .WB_PENDING  (pend)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drv(input logic w, input logic [2:0] wa, input logic [7:0] d,
                       input logic z, input logic st,
                       input logic [2:0] r1, input logic [2:0] r2);
        we    = w;
        waddr = wa;
        din   = d;
        zin   = z;
        stall = st;
        a1    = r1;
        a2    = r2;
    endtask

    task automatic exp_push(input string n, input logic [7:0] e1, input logic [7:0] e2,
                            input logic ezf, input logic epend);
        exp_t e;
        e.name = n;
        e.o1   = e1;
        e.o2   = e2;
        e.zf   = ezf;
        e.pend = epend;
        q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare the outputs once per cycle, mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if (out1 !== e.o1) begin
                    errors++;
                    $display("FAIL %s OUT1: got %h expected %h", e.name, out1, e.o1);
                end
                checks++;
                if (out2 !== e.o2) begin
                    errors++;
                    $display("FAIL %s OUT2: got %h expected %h", e.name, out2, e.o2);
                end
                checks++;
                if (zflag !== e.zf) begin
                    errors++;
                    $display("FAIL %s ZERO_FLAG: got %b expected %b", e.name, zflag, e.zf);
                end
                checks++;
                if (pend !== e.pend) begin
                    errors++;
                    $display("FAIL %s WB_PENDING: got %b expected %b", e.name, pend, e.pend);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        drv(0, 0, 8'h00, 0, 0, 0, 0);
        @(posedge clk);
        #1;

        // Reset state
        exp_push("rst_init", 8'h00, 8'h00, 0, 0);
        tick();

        // Write r3 then reset mid-cycle
        rst_n = 1'b1;
        drv(1, 3, 8'h55, 1, 0, 3, 3); exp_push("t1_pre",  8'h00, 8'h00, 0, 0); tick();
        drv(0, 0, 8'h00, 0, 0, 3, 3); exp_push("t1_byp",  8'h55, 8'h55, 0, 1); tick();
        drv(0, 0, 8'h00, 0, 0, 3, 3); exp_push("t1_arr",  8'h55, 8'h55, 1, 0); tick();
        rst_n = 1'b0;
        drv(0, 0, 8'h00, 0, 0, 3, 3); exp_push("t1_rst",  8'h00, 8'h00, 0, 0); tick();
        rst_n = 1'b1;
        drv(0, 0, 8'h00, 0, 0, 3, 3); exp_push("t1_post", 8'h00, 8'h00, 0, 0); tick();

        // Write/readback through bypass then array
        drv(1, 5, 8'h2A, 0, 0, 5, 3); exp_push("t2_pre",  8'h00, 8'h00, 0, 0); tick();
        drv(0, 0, 8'h00, 0, 0, 5, 3); exp_push("t2_byp",  8'h2A, 8'h00, 0, 1); tick();
        drv(0, 0, 8'h00, 0, 0, 5, 3); exp_push("t2_arr",  8'h2A, 8'h00, 0, 0); tick();

        // Back-to-back writes to r1
        drv(1, 1, 8'h10, 0, 0, 5, 1); exp_push("t3_e0",   8'h2A, 8'h00, 0, 0); tick();
        drv(1, 1, 8'h20, 0, 0, 5, 1); exp_push("t3_e1",   8'h2A, 8'h10, 0, 1); tick();
        drv(0, 0, 8'h00, 0, 0, 5, 1); exp_push("t3_e2",   8'h2A, 8'h20, 0, 1); tick();
        drv(0, 0, 8'h00, 0, 0, 1, 1); exp_push("t3_e3",   8'h20, 8'h20, 0, 0); tick();

        // Stall holds the pending write and blocks new capture
        drv(1, 2, 8'h7F, 0, 0, 2, 4); exp_push("t4_pre",  8'h00, 8'h00, 0, 0); tick();
        for (int i = 0; i < 3; i++) begin
            drv(1, 4, 8'hEE, 1, 1, 2, 4); exp_push("t4_stall", 8'h7F, 8'h00, 0, 1); tick();
        end
        drv(0, 0, 8'h00, 0, 0, 2, 4); exp_push("t4_rel",  8'h7F, 8'h00, 0, 1); tick();
        drv(0, 0, 8'h00, 0, 0, 2, 4); exp_push("t4_arr",  8'h7F, 8'h00, 0, 0); tick();

        // Zero flag follows commits, bubbles leave it alone; r0 is writable
        drv(1, 7, 8'h00, 1, 0, 7, 0); exp_push("t5_a",    8'h00, 8'h00, 0, 0); tick();
        drv(1, 0, 8'h04, 0, 0, 7, 0); exp_push("t5_b",    8'h00, 8'h00, 0, 1); tick();
        drv(0, 0, 8'h00, 1, 0, 7, 0); exp_push("t5_c",    8'h00, 8'h04, 1, 1); tick();
        drv(1, 7, 8'h00, 1, 0, 7, 0); exp_push("t5_d",    8'h00, 8'h04, 0, 0); tick();
        drv(0, 0, 8'h00, 1, 0, 7, 0); exp_push("t5_e",    8'h00, 8'h04, 0, 1); tick();
        drv(0, 0, 8'h00, 0, 0, 7, 0); exp_push("t5_f",    8'h00, 8'h04, 1, 0); tick();
        drv(0, 0, 8'h00, 0, 0, 7, 0); exp_push("t5_g",    8'h00, 8'h04, 1, 0); tick();

        // Reset discards a pending write and overrides stall
        drv(1, 6, 8'h99, 0, 0, 6, 2); exp_push("t6_pre",  8'h00, 8'h7F, 1, 0); tick();
        rst_n = 1'b0;
        drv(1, 6, 8'h99, 0, 1, 6, 2); exp_push("t6_rst",  8'h00, 8'h00, 0, 0); tick();
        rst_n = 1'b1;
        drv(0, 0, 8'h00, 0, 0, 6, 2); exp_push("t6_post", 8'h00, 8'h00, 0, 0); tick();
        drv(0, 0, 8'h00, 0, 0, 6, 5); exp_push("t6_post2",8'h00, 8'h00, 0, 0); tick();

        // Drain the scoreboard within a bounded number of cycles
        for (int i = 0; i < 10 && q.size() > 0; i++) begin
            tick();
        end
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
